// File: rtl/kronos_fetch_unit.sv
// Kronos instruction fetch stage: PC sequencing, word requests to instruction memory,
// single-entry skid buffer and branch redirect (including a request already in flight).
module kronos_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr_rdata,
    output logic [31:0] fetch_ir,
    output logic [31:0] fetch_pc,
    output logic        fetch_vld,
    input  logic        fetch_rdy,
    output logic [31:0] rf_instr_data,
    output logic        rf_instr_vld,
    input  logic        branch,
    input  logic [31:0] branch_target
);

    localparam logic [31:0] BOOT_WORD = BOOT_ADDR & ~32'h3;

    logic [31:0] addr_reg, ir_reg, pc_reg;
    logic [31:0] skid_ir_reg, skid_pc_reg, target_reg;
    logic        req_reg, vld_reg, skid_full_reg, discard_reg;

    logic        ack, load, load_skid, load_mem, to_skid, skid_full_next;
    logic [31:0] branch_word;

    always_comb begin
        branch_word    = branch_target & ~32'h3;
        ack            = req_reg & instr_ack;
        load           = ~vld_reg | fetch_rdy;
        load_skid      = ~branch & skid_full_reg & load;
        load_mem       = ~branch & ~discard_reg & ack & load & ~skid_full_reg;
        to_skid        = ~branch & ~discard_reg & ack & ~load;
        skid_full_next = ~branch & (to_skid | (skid_full_reg & ~load));
    end

    assign instr_addr    = addr_reg;
    assign instr_req     = req_reg;
    assign fetch_ir      = ir_reg;
    assign fetch_pc      = pc_reg;
    assign fetch_vld     = vld_reg;
    assign rf_instr_vld  = load_skid | load_mem;
    assign rf_instr_data = skid_full_reg ? skid_ir_reg : instr_rdata;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            addr_reg      <= BOOT_WORD;
            req_reg       <= 1'b0;
            ir_reg        <= 32'h0;
            pc_reg        <= 32'h0;
            vld_reg       <= 1'b0;
            skid_ir_reg   <= 32'h0;
            skid_pc_reg   <= 32'h0;
            skid_full_reg <= 1'b0;
            discard_reg   <= 1'b0;
            target_reg    <= 32'h0;
        end else begin
            skid_full_reg <= skid_full_next;
            // Requesting pauses whenever the skid buffer holds an instruction.
            req_reg       <= ~skid_full_next;

            if (branch) begin
                if (req_reg & ~instr_ack) begin
                    // Request in flight: keep its address until the ack, then redirect.
                    discard_reg <= 1'b1;
                    target_reg  <= branch_word;
                end else begin
                    discard_reg <= 1'b0;
                    addr_reg    <= branch_word;
                end
            end else if (ack) begin
                if (discard_reg) begin
                    discard_reg <= 1'b0;
                    addr_reg    <= target_reg;
                end else begin
                    addr_reg <= addr_reg + 32'd4;
                end
            end

            if (to_skid) begin
                skid_ir_reg <= instr_rdata;
                skid_pc_reg <= addr_reg;
            end

            if (branch) begin
                vld_reg <= 1'b0;
            end else if (load_skid) begin
                ir_reg  <= skid_ir_reg;
                pc_reg  <= skid_pc_reg;
                vld_reg <= 1'b1;
            end else if (load_mem) begin
                ir_reg  <= instr_rdata;
                pc_reg  <= addr_reg;
                vld_reg <= 1'b1;
            end else if (fetch_rdy) begin
                vld_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kronos_fetch_unit.sv
// Directed bench for kronos_fetch_unit: addr-as-data memory models with programmable wait states.
module tb_kronos_fetch_unit;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr, instr_rdata, fetch_ir, fetch_pc, rf_instr_data, branch_target;
    logic        instr_req, instr_ack, fetch_vld, fetch_rdy, rf_instr_vld, branch;

    logic [31:0] addr2, ir2, pc2, rfd2, bt2;
    logic        req2, vld2, rfv2, rdy2, br2;

    logic [3:0]  mem_wait;
    logic [3:0]  cnt;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    kronos_fetch_unit #(.BOOT_ADDR(32'h0)) dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack),
        .instr_rdata(instr_rdata),
        .fetch_ir(fetch_ir), .fetch_pc(fetch_pc), .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
        .rf_instr_data(rf_instr_data), .rf_instr_vld(rf_instr_vld),
        .branch(branch), .branch_target(branch_target)
    );

    kronos_fetch_unit #(.BOOT_ADDR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstz(rstz),
        .instr_addr(addr2), .instr_req(req2), .instr_ack(req2),
        .instr_rdata(addr2),
        .fetch_ir(ir2), .fetch_pc(pc2), .fetch_vld(vld2), .fetch_rdy(rdy2),
        .rf_instr_data(rfd2), .rf_instr_vld(rfv2),
        .branch(br2), .branch_target(bt2)
    );

    // Memory returns its address as data after mem_wait extra cycles.
    assign instr_ack   = instr_req && (cnt >= mem_wait);
    assign instr_rdata = instr_addr;

    always @(posedge clk or negedge rstz) begin
        if (!rstz)                       cnt <= 4'd0;
        else if (instr_req && !instr_ack) cnt <= cnt + 4'd1;
        else                             cnt <= 4'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for_addr(input logic [31:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (instr_req && instr_addr == a) return;
            step();
        end
        chk("timeout_addr", instr_addr, a);
    endtask

    task automatic wait_for_vld(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fetch_vld) return;
            step();
        end
        chk("timeout_vld", 32'(fetch_vld), 32'd1);
    endtask

    initial begin
        rstz = 1'b0; fetch_rdy = 1'b1; branch = 1'b0; branch_target = 32'h0; mem_wait = 4'd0;
        rdy2 = 1'b1; br2 = 1'b0; bt2 = 32'h0;
        step(); step();
        chk("rst_vld",  32'(fetch_vld), 32'd0);
        chk("rst_ir",   fetch_ir, 32'h0);
        chk("rst_pc",   fetch_pc, 32'h0);
        chk("rst_req",  32'(instr_req), 32'd0);
        chk("rst_addr", instr_addr, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);

        rstz = 1'b1;
        step();
        chk("start_req",    32'(instr_req), 32'd1);
        chk("start_addr",   instr_addr, 32'h0);
        chk("start_rfvld",  32'(rf_instr_vld), 32'd1);
        chk("start_rfdata", rf_instr_data, 32'h0);
        step();
        chk("seq_vld0", 32'(fetch_vld), 32'd1);
        chk("seq_pc0",  fetch_pc, 32'h0);
        chk("seq_rf0",  32'(rf_instr_vld), 32'd1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        step();
        chk("seq_pc4",  fetch_pc, 32'h4);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        chk("wrap_addr", addr2, 32'h0);

        // Stall four cycles while 0x4 is presented: 0x8 lands in the skid buffer.
        fetch_rdy = 1'b0;
        #1;
        chk("stall_rfvld", 32'(rf_instr_vld), 32'd0);
        chk("stall_req",   32'(instr_req), 32'd1);
        chk("stall_addr",  instr_addr, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) chk("wrap_pc2", pc2, 32'h0);
            chk("hold_pc",    fetch_pc, 32'h4);
            chk("hold_ir",    fetch_ir, 32'h4);
            chk("hold_req",   32'(instr_req), 32'd0);
            chk("hold_rfvld", 32'(rf_instr_vld), 32'd0);
        end
        step();
        fetch_rdy = 1'b1;
        #1;
        chk("drain_rfvld",  32'(rf_instr_vld), 32'd1);
        chk("drain_rfdata", rf_instr_data, 32'h8);
        chk("drain_req",    32'(instr_req), 32'd0);
        step();
        chk("drain_pc",   fetch_pc, 32'h8);
        chk("drain_ir",   fetch_ir, 32'h8);
        chk("resume_req", 32'(instr_req), 32'd1);
        chk("resume_addr", instr_addr, 32'hC);
        step();
        chk("after_pc", fetch_pc, 32'hC);

        // Branch coinciding with the ack for 0x20.
        wait_for_addr(32'h20, 20);
        branch = 1'b1; branch_target = 32'h40;
        #1;
        chk("brack_ack",   32'(instr_ack), 32'd1);
        chk("brack_rfvld", 32'(rf_instr_vld), 32'd0);
        step();
        branch = 1'b0;
        chk("brack_vld",  32'(fetch_vld), 32'd0);
        chk("brack_addr", instr_addr, 32'h40);
        chk("brack_req",  32'(instr_req), 32'd1);
        step();
        chk("brack_vld1", 32'(fetch_vld), 32'd1);
        chk("brack_pc",   fetch_pc, 32'h40);

        // Fill the skid buffer, then reset asynchronously mid-cycle.
        fetch_rdy = 1'b0;
        step();
        chk("skid_req", 32'(instr_req), 32'd0);
        mem_wait = 4'd3;
        #2;
        rstz = 1'b0;
        #1;
        chk("arst_vld",   32'(fetch_vld), 32'd0);
        chk("arst_pc",    fetch_pc, 32'h0);
        chk("arst_ir",    fetch_ir, 32'h0);
        chk("arst_req",   32'(instr_req), 32'd0);
        chk("arst_addr",  instr_addr, 32'h0);
        chk("arst_rfvld", 32'(rf_instr_vld), 32'd0);
        step(); step();
        fetch_rdy = 1'b1;
        rstz = 1'b1;
        step();
        chk("rel_req",  32'(instr_req), 32'd1);
        chk("rel_addr", instr_addr, 32'h0);
        chk("rel_wait", 32'(instr_ack), 32'd0);
        wait_for_vld(20);
        chk("rel_pc", fetch_pc, 32'h0);
        chk("rel_ir", fetch_ir, 32'h0);

        // Branch while the 0x10 request waits: its ack must be dropped.
        wait_for_addr(32'h10, 60);
        chk("pend_noack", 32'(instr_ack), 32'd0);
        branch = 1'b1; branch_target = 32'h103;
        #1;
        chk("pend_rfvld", 32'(rf_instr_vld), 32'd0);
        step();
        branch = 1'b0;
        chk("pend_vld", 32'(fetch_vld), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (instr_ack) break;
            chk("pend_addr", instr_addr, 32'h10);
            step();
        end
        chk("drop_ack",   32'(instr_ack), 32'd1);
        chk("drop_addr",  instr_addr, 32'h10);
        chk("drop_rfvld", 32'(rf_instr_vld), 32'd0);
        step();
        chk("redir_addr", instr_addr, 32'h100);
        chk("redir_req",  32'(instr_req), 32'd1);
        wait_for_vld(20);
        chk("redir_pc", fetch_pc, 32'h100);
        chk("redir_ir", fetch_ir, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
